// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, memory
// ctrl encodings, FSM state type and the access legality rule.
package lsu_pkg;

    // RV32I load/store width and signedness codes
    localparam logic [2:0] FUNCT3_B  = 3'b000;
    localparam logic [2:0] FUNCT3_H  = 3'b001;
    localparam logic [2:0] FUNCT3_W  = 3'b010;
    localparam logic [2:0] FUNCT3_BU = 3'b100;
    localparam logic [2:0] FUNCT3_HU = 3'b101;

    // combined_memory ctrl encodings
    localparam logic [2:0] MEM_CTRL_BYTE = 3'b000;
    localparam logic [2:0] MEM_CTRL_HALF = 3'b001;
    localparam logic [2:0] MEM_CTRL_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // An access is illegal for an unknown width code, a store with an
    // unsigned-load code, or an address not aligned to the access width.
    function automatic logic access_illegal(input logic       we,
                                            input logic [2:0] funct3,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (funct3)
            FUNCT3_B, FUNCT3_BU: bad = 1'b0;
            FUNCT3_H, FUNCT3_HU: bad = addr_lo[0];
            FUNCT3_W:            bad = (addr_lo != 2'b00);
            default:             bad = 1'b1;
        endcase
        if (we && funct3[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and combined_memory port of the load/store unit.
interface load_store_unit_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [2:0]           req_funct3;
    logic [WORD_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [WORD_SIZE-1:0] resp_rdata;
    logic                 resp_err;

    logic                 mem_write_en;
    logic [WORD_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_write_data;
    logic [2:0]           mem_ctrl;
    logic [WORD_SIZE-1:0] mem_data;

    // Load/store unit side
    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_write_en, mem_addr, mem_write_data, mem_ctrl,
        input  mem_data
    );

    // Pipeline stage and memory side
    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_write_en, mem_addr, mem_write_data, mem_ctrl,
        output mem_data
    );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational load-data extension: selects the low byte/halfword of a
// little-endian word and sign- or zero-extends it according to funct3.
module load_extend
    import lsu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [WORD_SIZE-1:0] word,
    input  logic [2:0]           funct3,
    output logic [WORD_SIZE-1:0] result
);

    // Width/sign selection; word accesses and unknown codes pass through
    always_comb begin
        result = word;
        case (funct3)
            FUNCT3_B:  result = {{(WORD_SIZE-8){word[7]}}, word[7:0]};
            FUNCT3_BU: result = {{(WORD_SIZE-8){1'b0}}, word[7:0]};
            FUNCT3_H:  result = {{(WORD_SIZE-16){word[15]}}, word[15:0]};
            FUNCT3_HU: result = {{(WORD_SIZE-16){1'b0}}, word[15:0]};
            default:   result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, validates it,
// performs a single-cycle access on combined_memory and holds the response
// until the consumer takes it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.master bus
);

    lsu_state_e           state_q, state_d;
    logic                 we_q, we_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] word_q, word_d;
    logic [WORD_SIZE-1:0] ext_data;

    load_extend #(
        .WORD_SIZE(WORD_SIZE)
    ) u_load_extend (
        .word  (word_q),
        .funct3(funct3_q),
        .result(ext_data)
    );

    // Next-state and capture logic; defaults hold every register
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        word_d   = word_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    err_d    = access_illegal(bus.req_we, bus.req_funct3,
                                              bus.req_addr[1:0]);
                    // Cleared so stores and errors return zero data
                    word_d   = '0;
                    state_d  = err_d ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    word_d = bus.mem_data;
                end
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured request; reset clears everything asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            word_q   <= word_d;
        end
    end

    // Outputs decoded from state so reset drops write enable immediately
    always_comb begin
        bus.req_ready      = (state_q == IDLE);
        bus.resp_valid     = (state_q == RESP);
        bus.resp_err       = (state_q == RESP) && err_q;
        bus.resp_rdata     = (state_q == RESP) ? ext_data : '0;
        bus.mem_write_en   = (state_q == ACCESS) && we_q;
        bus.mem_ctrl       = (state_q == ACCESS) ? {1'b0, funct3_q[1:0]}
                                                 : MEM_CTRL_WORD;
        bus.mem_addr       = addr_q;
        bus.mem_write_data = wdata_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory device, shadow memory
// reference and directed plus randomized load/store scenarios.
module tb_load_store_unit;

    logic clk;
    logic rst_n;

    load_store_unit_if #(.WORD_SIZE(32)) bus_if ();

    load_store_unit #(.WORD_SIZE(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory device (256 bytes, little-endian, async read)
    logic [7:0] mem [0:255];
    logic [7:0] shadow [0:255];
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_data;
    logic [7:0] ma;

    assign ma = bus_if.mem_addr[7:0];
    assign bus_if.mem_data = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)],
                              mem[8'(ma + 8'd1)], mem[ma]};

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (bus_if.mem_write_en) begin
            mem[ma] <= bus_if.mem_write_data[7:0];
            if (bus_if.mem_ctrl != 3'b000) begin
                mem[8'(ma + 8'd1)] <= bus_if.mem_write_data[15:8];
            end
            if (bus_if.mem_ctrl == 3'b010) begin
                mem[8'(ma + 8'd2)] <= bus_if.mem_write_data[23:16];
                mem[8'(ma + 8'd3)] <= bus_if.mem_write_data[31:24];
            end
        end
    end

    // Reference model
    function automatic bit exp_legal(input logic we, input logic [2:0] f3,
                                     input logic [7:0] a);
        int width;
        case (f3)
            3'd0, 3'd4: width = 1;
            3'd1, 3'd5: width = 2;
            3'd2:       width = 4;
            default:    return 1'b0;
        endcase
        if (we && f3 > 3'd3) return 1'b0;
        return (int'(a) % width) == 0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3,
                                             input logic [7:0] a);
        int unsigned b0, b1, b2, b3, h, w;
        int          s;
        b0 = shadow[a];
        b1 = shadow[8'(a + 8'd1)];
        b2 = shadow[8'(a + 8'd2)];
        b3 = shadow[8'(a + 8'd3)];
        h  = b0 + 256 * b1;
        w  = h + 65536 * (b2 + 256 * b3);
        case (f3)
            3'd0: begin s = (b0 >= 128) ? int'(b0) - 256 : int'(b0); return 32'(s); end
            3'd4: return 32'(b0);
            3'd1: begin s = (h >= 32768) ? int'(h) - 65536 : int'(h); return 32'(s); end
            3'd5: return 32'(h);
            default: return 32'(w);
        endcase
    endfunction

    task automatic shadow_store(input logic [2:0] f3, input logic [7:0] a,
                                input logic [31:0] wd);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) begin
            shadow[8'(int'(a) + i)] = 8'((wd >> (8 * i)) & 32'hFF);
        end
    endtask

    task automatic backdoor_byte(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = b;
        shadow[a] = b;
        @(posedge clk);
        #1 bd_we = 1'b0;
    endtask

    // One complete transaction; returns what was observed
    task automatic run_txn(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e,
                           output int lat, output int nwe,
                           output logic [2:0] wctrl);
        @(negedge clk);
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = a;
        bus_if.req_wdata  = wd;
        bus_if.resp_ready = 1'b0;
        @(posedge clk);
        lat   = 0;
        nwe   = 0;
        wctrl = 3'b111;
        while (lat < 8) begin
            @(negedge clk);
            bus_if.req_valid = 1'b0;
            lat++;
            if (bus_if.mem_write_en) begin
                nwe++;
                wctrl = bus_if.mem_ctrl;
            end
            if (bus_if.resp_valid) break;
        end
        rd = bus_if.resp_rdata;
        e  = bus_if.resp_err;
        bus_if.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus_if.req_valid = 1'b0; bus_if.req_we = 1'b0; bus_if.req_funct3 = 3'b000;
        bus_if.req_addr = '0; bus_if.req_wdata = '0; bus_if.resp_ready = 1'b0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        for (int i = 0; i < 256; i++) backdoor_byte(8'(i), 8'($urandom));
        backdoor_byte(8'h18, 8'h78);
        backdoor_byte(8'h19, 8'h56);
        backdoor_byte(8'h1A, 8'h34);
        backdoor_byte(8'h1B, 8'h12);
        @(negedge clk);
        n_cmp++; if (bus_if.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", bus_if.req_ready); end
        n_cmp++; if (bus_if.resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", bus_if.resp_valid); end
        n_cmp++; if (bus_if.resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err: got %b want 0", bus_if.resp_err); end
        n_cmp++; if (bus_if.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata: got %h want 0", bus_if.resp_rdata); end
        n_cmp++; if (bus_if.mem_write_en !== 1'b0) begin n_bad++; $display("FAIL reset_mem_write_en: got %b want 0", bus_if.mem_write_en); end
        n_cmp++; if (bus_if.mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", bus_if.mem_addr); end
        n_cmp++; if (bus_if.mem_write_data !== 32'h0) begin n_bad++; $display("FAIL reset_mem_wdata: got %h want 0", bus_if.mem_write_data); end
        n_cmp++; if (bus_if.mem_ctrl !== 3'b010) begin n_bad++; $display("FAIL reset_mem_ctrl: got %b want 010", bus_if.mem_ctrl); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lw;
        logic [31:0] rd; logic e; int lat, nwe; logic [2:0] wc;
        run_txn(1'b0, 3'b010, 32'h18, 32'h0, rd, e, lat, nwe, wc);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL lw_rdata: got %h want 12345678", rd); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL lw_err: got %b want 0", e); end
        n_cmp++; if (nwe !== 0) begin n_bad++; $display("FAIL lw_no_write: got %0d want 0", nwe); end
    endtask

    task automatic test_sb_lb;
        logic [31:0] rd; logic e; int lat, nwe; logic [2:0] wc;
        run_txn(1'b1, 3'b000, 32'h18, 32'hAABBCC77, rd, e, lat, nwe, wc);
        shadow_store(3'b000, 8'h18, 32'hAABBCC77);
        n_cmp++; if (nwe !== 1) begin n_bad++; $display("FAIL sb_write_cycles: got %0d want 1", nwe); end
        n_cmp++; if (wc !== 3'b000) begin n_bad++; $display("FAIL sb_ctrl: got %b want 000", wc); end
        n_cmp++; if (lat !== 2 || e !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sb_resp: got lat %0d err %b rdata %h want 2 0 0", lat, e, rd); end
        n_cmp++; if (mem[8'h19] !== 8'h56) begin n_bad++; $display("FAIL sb_neighbour: got %h want 56", mem[8'h19]); end
        run_txn(1'b0, 3'b000, 32'h18, 32'h0, rd, e, lat, nwe, wc);
        n_cmp++; if (rd !== 32'h00000077) begin n_bad++; $display("FAIL lb_pos: got %h want 00000077", rd); end
        run_txn(1'b1, 3'b000, 32'h18, 32'h12345680, rd, e, lat, nwe, wc);
        shadow_store(3'b000, 8'h18, 32'h12345680);
        run_txn(1'b0, 3'b000, 32'h18, 32'h0, rd, e, lat, nwe, wc);
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_neg: got %h want ffffff80", rd); end
        run_txn(1'b0, 3'b100, 32'h18, 32'h0, rd, e, lat, nwe, wc);
        n_cmp++; if (rd !== 32'h00000080) begin n_bad++; $display("FAIL lbu: got %h want 00000080", rd); end
        run_txn(1'b0, 3'b001, 32'h18, 32'h0, rd, e, lat, nwe, wc);
        n_cmp++; if (rd !== 32'h00005680) begin n_bad++; $display("FAIL lh: got %h want 00005680", rd); end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic e; int lat, nwe; logic [2:0] wc;
        run_txn(1'b0, 3'b001, 32'h19, 32'h0, rd, e, lat, nwe, wc);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL lh_mis_latency: got %0d want 1", lat); end
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL lh_mis_err: got %b want 1", e); end
        n_cmp++; if (rd !== 32'h0 || nwe !== 0) begin n_bad++; $display("FAIL lh_mis_data: got rdata %h writes %0d want 0 0", rd, nwe); end
        run_txn(1'b1, 3'b010, 32'h1A, 32'hCAFEF00D, rd, e, lat, nwe, wc);
        n_cmp++; if (lat !== 1 || e !== 1'b1) begin n_bad++; $display("FAIL sw_mis_resp: got lat %0d err %b want 1 1", lat, e); end
        n_cmp++; if (nwe !== 0) begin n_bad++; $display("FAIL sw_mis_write: got %0d want 0", nwe); end
        for (int i = 8'h18; i < 8'h1E; i++) begin
            n_cmp++; if (mem[8'(i)] !== shadow[8'(i)]) begin n_bad++; $display("FAIL sw_mis_mem[%0h]: got %h want %h", i, mem[8'(i)], shadow[8'(i)]); end
        end
    endtask

    task automatic test_bad_funct3;
        logic [31:0] rd; logic e; int lat, nwe; logic [2:0] wc;
        run_txn(1'b0, 3'b011, 32'h20, 32'h0, rd, e, lat, nwe, wc);
        n_cmp++; if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || nwe !== 0) begin n_bad++; $display("FAIL funct3_011: got lat %0d err %b rdata %h writes %0d want 1 1 0 0", lat, e, rd, nwe); end
        run_txn(1'b1, 3'b100, 32'h20, 32'h11223344, rd, e, lat, nwe, wc);
        n_cmp++; if (lat !== 1 || e !== 1'b1 || nwe !== 0) begin n_bad++; $display("FAIL store_bu: got lat %0d err %b writes %0d want 1 1 0", lat, e, nwe); end
    endtask

    task automatic test_backpressure;
        logic [31:0] want;
        int          waited;
        want = exp_load(3'b010, 8'h18);
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b0; bus_if.req_funct3 = 3'b010;
        bus_if.req_addr = 32'h18; bus_if.resp_ready = 1'b0;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        waited = 0;
        while (!bus_if.resp_valid && waited < 8) begin @(negedge clk); waited++; end
        n_cmp++; if (waited !== 1) begin n_bad++; $display("FAIL bp_latency: got %0d want 1", waited); end
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_funct3 = 3'b010;
        bus_if.req_addr = 32'h30; bus_if.req_wdata = 32'h55AA55AA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (bus_if.resp_valid !== 1'b1 || bus_if.resp_rdata !== want) begin n_bad++; $display("FAIL bp_hold[%0d]: got valid %b rdata %h want 1 %h", c, bus_if.resp_valid, bus_if.resp_rdata, want); end
            n_cmp++; if (bus_if.req_ready !== 1'b0 || bus_if.mem_write_en !== 1'b0) begin n_bad++; $display("FAIL bp_blocked[%0d]: got ready %b we %b want 0 0", c, bus_if.req_ready, bus_if.mem_write_en); end
        end
        bus_if.resp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus_if.resp_valid !== 1'b0 || bus_if.req_ready !== 1'b1 || bus_if.mem_write_en !== 1'b0) begin n_bad++; $display("FAIL bp_release: got valid %b ready %b we %b want 0 1 0", bus_if.resp_valid, bus_if.req_ready, bus_if.mem_write_en); end
        bus_if.req_valid = 1'b0; bus_if.resp_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if ({mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} !== {shadow[8'h33], shadow[8'h32], shadow[8'h31], shadow[8'h30]}) begin n_bad++; $display("FAIL bp_mem: got %h want %h", {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]}, {shadow[8'h33], shadow[8'h32], shadow[8'h31], shadow[8'h30]}); end
    endtask

    task automatic test_reset_mid_store;
        @(negedge clk);
        bus_if.req_valid = 1'b1; bus_if.req_we = 1'b1; bus_if.req_funct3 = 3'b010;
        bus_if.req_addr = 32'h40; bus_if.req_wdata = 32'hDEADBEEF; bus_if.resp_ready = 1'b0;
        @(posedge clk);
        #2;
        bus_if.req_valid = 1'b0;
        n_cmp++; if (bus_if.mem_write_en !== 1'b1) begin n_bad++; $display("FAIL rst_pre_we: got %b want 1", bus_if.mem_write_en); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_if.mem_write_en !== 1'b0) begin n_bad++; $display("FAIL rst_we_drop: got %b want 0", bus_if.mem_write_en); end
        n_cmp++; if (bus_if.mem_addr !== 32'h0 || bus_if.mem_write_data !== 32'h0) begin n_bad++; $display("FAIL rst_mem_bus: got addr %h data %h want 0 0", bus_if.mem_addr, bus_if.mem_write_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 8'h40; i < 8'h44; i++) begin
            n_cmp++; if (mem[8'(i)] !== shadow[8'(i)]) begin n_bad++; $display("FAIL rst_mem[%0h]: got %h want %h", i, mem[8'(i)], shadow[8'(i)]); end
        end
        n_cmp++; if (bus_if.req_ready !== 1'b1 || bus_if.resp_valid !== 1'b0 || bus_if.resp_err !== 1'b0 || bus_if.resp_rdata !== 32'h0 || bus_if.mem_write_en !== 1'b0) begin n_bad++; $display("FAIL rst_after: got ready %b valid %b err %b rdata %h we %b want 1 0 0 0 0", bus_if.req_ready, bus_if.resp_valid, bus_if.resp_err, bus_if.resp_rdata, bus_if.mem_write_en); end
    endtask

    task automatic test_random;
        logic [31:0] rd, wd, want_rd; logic e; int lat, nwe; logic [2:0] wc, f3;
        logic we; logic [7:0] a; bit legal; int diffs;
        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom % 2);
            f3 = 3'($urandom % 8);
            a  = 8'($urandom_range(0, 255));
            wd = $urandom;
            legal   = exp_legal(we, f3, a);
            want_rd = (legal && !we) ? exp_load(f3, a) : 32'h0;
            run_txn(we, f3, {24'h0, a}, wd, rd, e, lat, nwe, wc);
            if (legal && we) shadow_store(f3, a, wd);
            n_cmp++; if (lat !== (legal ? 2 : 1)) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, legal ? 2 : 1); end
            n_cmp++; if (e !== !legal) begin n_bad++; $display("FAIL rnd%0d_err: got %b want %b", t, e, !legal); end
            n_cmp++; if (rd !== want_rd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", t, rd, want_rd); end
            n_cmp++; if (nwe !== ((legal && we) ? 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_writes: got %0d want %0d", t, nwe, (legal && we) ? 1 : 0); end
            if (legal && we) begin
                n_cmp++; if (wc !== {1'b0, f3[1:0]}) begin n_bad++; $display("FAIL rnd%0d_ctrl: got %b want %b", t, wc, {1'b0, f3[1:0]}); end
            end
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[8'(i)] !== shadow[8'(i)]) diffs++;
        n_cmp++; if (diffs !== 0) begin n_bad++; $display("FAIL rnd_mem_image: got %0d differing bytes want 0", diffs); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb_lb();
        test_illegal();
        test_bad_funct3();
        test_backpressure();
        test_reset_mid_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory port: accepts load/store requests from the execute stage, checks alignment and `funct3`, drives the byte-addressable `combined_memory` port (`write_en`/`addr`/`write_data`/`ctrl`/`data`), and returns sign- or zero-extended load data or store completion. It sits between the pipeline's EX/MEM stage and the memory. A small FSM serialises accesses with a valid/ready handshake on both request and response.

## Interface
- `WORD_SIZE`, 32, data and address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request (IDLE only)
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `req_addr`  in  WORD_SIZE  byte address
- `req_wdata`  in  WORD_SIZE  store data; low bytes used
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer takes response
- `resp_rdata`  out  WORD_SIZE  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned address or illegal `funct3`
- `mem_write_en`  out  1  to memory `write_en`
- `mem_addr`  out  WORD_SIZE  to memory `addr`
- `mem_write_data`  out  WORD_SIZE  to memory `write_data`
- `mem_ctrl`  out  3  to memory `ctrl`
- `mem_data`  in  WORD_SIZE  from memory `data` (asynchronous read, little-endian)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture `we`, `funct3`, `addr`, `wdata`.
  - If the access is legal, go to ACCESS.
  - If it is illegal, go directly to RESP with `resp_err`=1.
- Illegal access:
  - `funct3` is 011, 110 or 111, or a store with `funct3[2]`=1.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - An illegal access never asserts `mem_write_en`.
- ACCESS (one cycle):
  - `mem_addr` = captured address.
  - `mem_ctrl` = {1'b0, `funct3[1:0]`}.
  - `mem_write_data` = captured wdata (no lane shifting; memory is byte-addressed).
  - Store: `mem_write_en`=1.
  - Load: register `mem_data` at the end of the cycle.
  - Always go to RESP.
- RESP: `resp_valid`=1, outputs stable, return to IDLE when `resp_ready`=1.
  - No new request is accepted in the same cycle as the RESP→IDLE transition.
- Load extension of the registered word:
  - B: sign-extend bits [7:0].
  - BU: zero-extend bits [7:0].
  - H: sign-extend bits [15:0].
  - HU: zero-extend bits [15:0].
  - W: pass all 32 bits.
- Outside ACCESS: `mem_write_en`=0 and `mem_ctrl`=010. `mem_addr` and `mem_write_data` hold their last captured values.

## Timing
- Reset (`rst_n` low, any state):
  - State goes to IDLE immediately.
  - `mem_write_en`, `resp_valid`, `resp_err`, `resp_rdata` and `mem_addr`/`mem_write_data` go to 0.
  - `req_ready`=1.
  - A mid-ACCESS store is aborted and the memory write suppressed, because `mem_write_en` drops asynchronously.
- Legal access accepted in cycle N:
  - ACCESS in N+1; the store is written at the N+1→N+2 edge.
  - `resp_valid` from N+2 until the handshake.
  - Best-case throughput is one access per 3 cycles (accept, access, respond).
- Illegal access accepted in cycle N: `resp_valid`/`resp_err` in N+1.
- Back-pressure: `resp_ready` held low leaves RESP outputs frozen indefinitely, and `req_ready` stays 0.
- `req_valid` while not in IDLE: ignored. The requester must hold the request.

## Structure
- Package `lsu_pkg`:
  - `funct3` localparams FUNCT3_B/H/W/BU/HU.
  - Memory ctrl encodings BYTE/HALF/WORD.
  - State enum IDLE/ACCESS/RESP.
- Sub-module `load_extend` (combinational): word + `funct3` → extended result. It is reused by any future MMIO load path.

## Test plan
- LW to 0x18 where memory holds 0x12345678 → `resp_valid` at N+2, `resp_rdata`=0x12345678, `resp_err`=0.
- SB with wdata 0xAABBCC77 to 0x18, then LB 0x18 → one cycle of `mem_write_en` with `mem_ctrl`=000; load returns 0x00000077. With memory byte 0x80, LB returns 0xFFFFFF80 and LBU returns 0x00000080.
- LH at 0x19 → `resp_err`=1 at N+1, `mem_write_en` never asserted, `resp_rdata`=0. SW at 0x1A → same behaviour, and the memory is unchanged.
- `resp_ready` held low for 5 cycles after a load → `resp_valid` and data stable, `req_ready`=0 throughout, and a new `req_valid` is ignored.
- `rst_n` pulsed low during ACCESS of SW 0xDEADBEEF → `mem_write_en` drops immediately, target bytes keep their old value, and after release `req_ready`=1 with all outputs 0.
- `funct3`=011 load → error response with no memory access.
